// File: rtl/nco_pkg.sv
// Shared definitions for the NCO phase-generation stage: width, FSM states and
// the sweep-limit compare used by the chirp logic.
package nco_pkg;

    localparam int PHASE_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_SWEEP = 2'd2
    } nco_state_e;

    // True when one more step would reach or pass lim. Carry on an upward step
    // and borrow (no carry) on a downward step both count as passing the limit.
    function automatic logic sweep_reached(
        input logic [PHASE_W-1:0] fcw,
        input logic [PHASE_W-1:0] step,
        input logic [PHASE_W-1:0] lim
    );
        logic [PHASE_W:0] sum;
        sum = {1'b0, fcw} + {1'b0, step};
        if (step[PHASE_W-1]) begin
            return !sum[PHASE_W] || (sum[PHASE_W-1:0] <= lim);
        end
        return sum[PHASE_W] || (sum[PHASE_W-1:0] >= lim);
    endfunction

endpackage

// File: rtl/nco_phase_accumulator_if.sv
// Control/data bundle between the NCO phase stage and whatever drives it.
interface nco_phase_accumulator_if;
    import nco_pkg::*;

    logic [PHASE_W-1:0] fcw_in;
    logic               fcw_valid;
    logic               fcw_ready;
    logic [PHASE_W-1:0] off_in;
    logic               off_load;
    logic               start;
    logic               stop;
    logic               clear;
    logic               sweep_start;
    logic [PHASE_W-1:0] sweep_step;
    logic [PHASE_W-1:0] sweep_limit;
    logic [PHASE_W-1:0] phase_out;
    logic               phase_valid;
    logic               wrap;
    logic               sweep_done;

    modport master (
        output fcw_in, fcw_valid, off_in, off_load, start, stop, clear,
               sweep_start, sweep_step, sweep_limit,
        input  fcw_ready, phase_out, phase_valid, wrap, sweep_done
    );

    modport slave (
        input  fcw_in, fcw_valid, off_in, off_load, start, stop, clear,
               sweep_start, sweep_step, sweep_limit,
        output fcw_ready, phase_out, phase_valid, wrap, sweep_done
    );

endinterface

// File: rtl/nco_fcw_sweep.sv
// Active frequency control word: handshake load, latched sweep parameters and
// the per-cycle chirp step with clamp at the limit.
module nco_fcw_sweep
    import nco_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [PHASE_W-1:0] fcw_in,
    input  logic               fcw_valid,
    input  logic               fcw_ready,
    input  logic               in_sweep,
    input  logic               sweep_go,
    input  logic               stop,
    input  logic [PHASE_W-1:0] sweep_step,
    input  logic [PHASE_W-1:0] sweep_limit,
    output logic [PHASE_W-1:0] fcw_act,
    output logic               reached,
    output logic               sweep_done
);

    logic [PHASE_W-1:0] fcw_act_reg;
    logic [PHASE_W-1:0] step_reg;
    logic [PHASE_W-1:0] lim_reg;
    logic               done_reg;

    assign reached    = in_sweep && sweep_reached(fcw_act_reg, step_reg, lim_reg);
    assign fcw_act    = fcw_act_reg;
    assign sweep_done = done_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fcw_act_reg <= '0;
            step_reg    <= '0;
            lim_reg     <= '0;
            done_reg    <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            // fcw_ready is low throughout SWEEP, so a load and a step never collide.
            if (fcw_valid && fcw_ready) begin
                fcw_act_reg <= fcw_in;
            end else if (in_sweep && !stop) begin
                if (reached) begin
                    fcw_act_reg <= lim_reg;
                    done_reg    <= 1'b1;
                end else begin
                    fcw_act_reg <= fcw_act_reg + step_reg;
                end
            end
            if (sweep_go) begin
                step_reg <= sweep_step;
                lim_reg  <= sweep_limit;
            end
        end
    end

endmodule

// File: rtl/nco_phase_accumulator.sv
// NCO phase stage: integrates the active FCW, adds the phase offset and drives a
// registered phase word plus wrap/valid flags to the quantizer.
module nco_phase_accumulator
    import nco_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    nco_phase_accumulator_if.slave bus
);

    nco_state_e         state_reg;
    nco_state_e         state_next;
    logic [PHASE_W-1:0] acc_reg;
    logic [PHASE_W-1:0] off_reg;
    logic [PHASE_W-1:0] phase_reg;
    logic               carry_reg;
    logic               valid_reg;
    logic               wrap_reg;

    logic [PHASE_W-1:0] fcw_act;
    logic [PHASE_W:0]   acc_sum;
    logic               in_sweep;
    logic               sweep_go;
    logic               reached;
    logic               fcw_ready_w;

    assign in_sweep    = (state_reg == ST_SWEEP);
    assign fcw_ready_w = !in_sweep;
    assign sweep_go    = (state_reg == ST_RUN) && bus.sweep_start && !bus.stop
                         && (bus.sweep_step != '0);
    assign acc_sum     = {1'b0, acc_reg} + {1'b0, fcw_act};

    nco_fcw_sweep u_fcw_sweep (
        .clk         (clk),
        .rst         (rst),
        .fcw_in      (bus.fcw_in),
        .fcw_valid   (bus.fcw_valid),
        .fcw_ready   (fcw_ready_w),
        .in_sweep    (in_sweep),
        .sweep_go    (sweep_go),
        .stop        (bus.stop),
        .sweep_step  (bus.sweep_step),
        .sweep_limit (bus.sweep_limit),
        .fcw_act     (fcw_act),
        .reached     (reached),
        .sweep_done  (bus.sweep_done)
    );

    always_comb begin
        state_next = state_reg;
        if (bus.stop) begin
            state_next = ST_IDLE;
        end else begin
            case (state_reg)
                ST_IDLE:  if (bus.start) state_next = ST_RUN;
                ST_RUN:   if (sweep_go)  state_next = ST_SWEEP;
                ST_SWEEP: if (reached)   state_next = ST_RUN;
                default:  state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            acc_reg   <= '0;
            carry_reg <= 1'b0;
            off_reg   <= '0;
            phase_reg <= '0;
            valid_reg <= 1'b0;
            wrap_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            // clear wins over the increment; the carry only marks real updates.
            if (bus.clear) begin
                acc_reg   <= '0;
                carry_reg <= 1'b0;
            end else if (state_reg != ST_IDLE) begin
                acc_reg   <= acc_sum[PHASE_W-1:0];
                carry_reg <= acc_sum[PHASE_W];
            end else begin
                carry_reg <= 1'b0;
            end
            if (bus.off_load) begin
                off_reg <= bus.off_in;
            end
            phase_reg <= acc_reg + off_reg;
            valid_reg <= (state_reg != ST_IDLE);
            wrap_reg  <= carry_reg;
        end
    end

    assign bus.fcw_ready   = fcw_ready_w;
    assign bus.phase_out   = phase_reg;
    assign bus.phase_valid = valid_reg;
    assign bus.wrap        = wrap_reg;

endmodule

// File: tb/tb_nco_phase_accumulator.sv
// Bench for nco_phase_accumulator: directed scenarios plus random traffic, all
// compared against a cycle-level arithmetic model of the phase stage.
module tb_nco_phase_accumulator;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    nco_phase_accumulator_if bus();

    nco_phase_accumulator dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    localparam int S_IDLE  = 0;
    localparam int S_RUN   = 1;
    localparam int S_SWEEP = 2;

    int unsigned m_acc, m_fcw, m_off, m_step, m_lim, m_phase;
    bit          m_carry, m_valid, m_wrap, m_done;
    int          m_st;

    task automatic model_reset();
        m_acc = 0; m_fcw = 0; m_off = 0; m_step = 0; m_lim = 0; m_phase = 0;
        m_carry = 0; m_valid = 0; m_wrap = 0; m_done = 0; m_st = S_IDLE;
    endtask

    task automatic idle_inputs();
        bus.fcw_in = '0; bus.fcw_valid = 1'b0; bus.off_in = '0; bus.off_load = 1'b0;
        bus.start = 1'b0; bus.stop = 1'b0; bus.clear = 1'b0; bus.sweep_start = 1'b0;
        bus.sweep_step = '0; bus.sweep_limit = '0;
    endtask

    // Advance the model by one clock using the inputs now on the bus, then clock the DUT.
    task automatic tick();
        longint      sum, target, lim64;
        int          sstep;
        bit          hit;
        int unsigned n_acc, n_fcw, n_off, n_step, n_lim;
        int          n_st;
        bit          n_carry, n_done;
        n_acc = m_acc; n_fcw = m_fcw; n_off = m_off; n_step = m_step; n_lim = m_lim;
        n_st = m_st; n_carry = 0; n_done = 0;
        if (m_st != S_IDLE) begin
            sum     = longint'(m_acc) + longint'(m_fcw);
            n_acc   = m_acc + m_fcw;
            n_carry = (sum >> 32) != 0;
        end
        if (bus.clear) begin
            n_acc = 0; n_carry = 0;
        end
        if (bus.fcw_valid && m_st != S_SWEEP) n_fcw = bus.fcw_in;
        if (bus.stop) begin
            n_st = S_IDLE;
        end else if (m_st == S_IDLE) begin
            if (bus.start) n_st = S_RUN;
        end else if (m_st == S_RUN) begin
            if (bus.sweep_start && bus.sweep_step != 0) begin
                n_st = S_SWEEP; n_step = bus.sweep_step; n_lim = bus.sweep_limit;
            end
        end else begin
            sstep  = int'(m_step);
            target = longint'(m_fcw) + longint'(sstep);
            lim64  = longint'(m_lim);
            hit    = (sstep > 0) ? (target >= lim64) : (target <= lim64);
            if (hit) begin
                n_fcw = m_lim; n_done = 1; n_st = S_RUN;
            end else begin
                n_fcw = m_fcw + m_step;
            end
        end
        if (bus.off_load) n_off = bus.off_in;
        m_phase = m_acc + m_off;
        m_valid = (m_st != S_IDLE);
        m_wrap  = m_carry;
        m_done  = n_done;
        m_acc = n_acc; m_fcw = n_fcw; m_off = n_off; m_step = n_step; m_lim = n_lim;
        m_st = n_st; m_carry = n_carry;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        model_reset();
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        total++; if (bus.phase_out !== 32'h0) begin bad++; $display("FAIL reset_phase got %h want 0", bus.phase_out); end
        total++; if (bus.phase_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got %b want 0", bus.phase_valid); end
        total++; if (bus.wrap !== 1'b0) begin bad++; $display("FAIL reset_wrap got %b want 0", bus.wrap); end
        total++; if (bus.sweep_done !== 1'b0) begin bad++; $display("FAIL reset_done got %b want 0", bus.sweep_done); end
        total++; if (bus.fcw_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got %b want 1", bus.fcw_ready); end
        rst = 1'b0;
        $display("test_reset: done");
    endtask

    task automatic test_wrap();
        logic [31:0] exp_ph [4];
        exp_ph = '{32'h4000_0000, 32'h8000_0000, 32'hC000_0000, 32'h0000_0000};
        bus.fcw_in = 32'h4000_0000; bus.fcw_valid = 1'b1;
        total++; if (bus.fcw_ready !== 1'b1) begin bad++; $display("FAIL wrap_ready got %b want 1", bus.fcw_ready); end
        tick();
        bus.fcw_valid = 1'b0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            tick();
            total++; if (bus.phase_out !== exp_ph[i]) begin bad++; $display("FAIL wrap_phase[%0d] got %h want %h", i, bus.phase_out, exp_ph[i]); end
            total++; if (bus.wrap !== (i == 3)) begin bad++; $display("FAIL wrap_flag[%0d] got %b want %b", i, bus.wrap, i == 3); end
            $display("test_wrap: sample %0d phase=%h wrap=%b", i, bus.phase_out, bus.wrap);
        end
    endtask

    task automatic test_offset();
        logic [31:0] prev;
        bus.stop = 1'b1; tick(); bus.stop = 1'b0;
        bus.fcw_in = 32'h1000_0000; bus.fcw_valid = 1'b1; bus.start = 1'b1;
        tick();
        bus.fcw_valid = 1'b0; bus.start = 1'b0;
        repeat (3) tick();
        prev = bus.phase_out;
        bus.off_in = 32'h8000_0000; bus.off_load = 1'b1;
        tick();
        bus.off_load = 1'b0;
        total++; if (bus.phase_out !== prev + 32'h1000_0000) begin bad++; $display("FAIL off_before got %h want %h", bus.phase_out, prev + 32'h1000_0000); end
        prev = bus.phase_out;
        tick();
        total++; if (bus.phase_out !== prev + 32'h9000_0000) begin bad++; $display("FAIL off_jump got %h want %h", bus.phase_out, prev + 32'h9000_0000); end
        prev = bus.phase_out;
        tick();
        total++; if (bus.phase_out !== prev + 32'h1000_0000) begin bad++; $display("FAIL off_after got %h want %h", bus.phase_out, prev + 32'h1000_0000); end
        total++; if (bus.phase_out !== m_phase) begin bad++; $display("FAIL off_model got %h want %h", bus.phase_out, m_phase); end
        $display("test_offset: phase=%h", bus.phase_out);
    endtask

    task automatic test_sweep_up();
        logic [31:0] prev, delta;
        logic [31:0] exp_d [4];
        exp_d = '{32'h200, 32'h300, 32'h400, 32'h480};
        bus.stop = 1'b1; tick(); bus.stop = 1'b0;
        bus.fcw_in = 32'h100; bus.fcw_valid = 1'b1; bus.start = 1'b1;
        tick();
        bus.fcw_valid = 1'b0; bus.start = 1'b0;
        repeat (2) tick();
        bus.sweep_step = 32'h100; bus.sweep_limit = 32'h480; bus.sweep_start = 1'b1;
        tick();
        bus.sweep_start = 1'b0;
        prev = bus.phase_out;
        for (int i = 1; i <= 7; i++) begin
            tick();
            delta = bus.phase_out - prev;
            prev  = bus.phase_out;
            if (i >= 3 && i <= 6) begin
                total++; if (delta !== exp_d[i-3]) begin bad++; $display("FAIL sweep_up_fcw[%0d] got %h want %h", i, delta, exp_d[i-3]); end
            end
            total++; if (bus.sweep_done !== (i == 4)) begin bad++; $display("FAIL sweep_up_done[%0d] got %b want %b", i, bus.sweep_done, i == 4); end
            total++; if (bus.fcw_ready !== (i >= 4)) begin bad++; $display("FAIL sweep_up_ready[%0d] got %b want %b", i, bus.fcw_ready, i >= 4); end
            total++; if (bus.phase_out !== m_phase) begin bad++; $display("FAIL sweep_up_model[%0d] got %h want %h", i, bus.phase_out, m_phase); end
            $display("test_sweep_up: cycle %0d delta=%h done=%b", i, delta, bus.sweep_done);
        end
    endtask

    task automatic test_sweep_down();
        logic [31:0] prev, delta;
        logic [31:0] exp_d [4];
        exp_d = '{32'h300, 32'h100, 32'h50, 32'h50};
        // FCW load and sweep_start together: the sweep starts from the new word.
        bus.fcw_in = 32'h300; bus.fcw_valid = 1'b1;
        bus.sweep_step = 32'hFFFF_FE00; bus.sweep_limit = 32'h50; bus.sweep_start = 1'b1;
        tick();
        bus.fcw_valid = 1'b0; bus.sweep_start = 1'b0;
        prev = bus.phase_out;
        for (int i = 1; i <= 5; i++) begin
            tick();
            delta = bus.phase_out - prev;
            prev  = bus.phase_out;
            if (i >= 2) begin
                total++; if (delta !== exp_d[i-2]) begin bad++; $display("FAIL sweep_dn_fcw[%0d] got %h want %h", i, delta, exp_d[i-2]); end
            end
            total++; if (bus.sweep_done !== (i == 2)) begin bad++; $display("FAIL sweep_dn_done[%0d] got %b want %b", i, bus.sweep_done, i == 2); end
            total++; if (bus.fcw_ready !== (i >= 2)) begin bad++; $display("FAIL sweep_dn_ready[%0d] got %b want %b", i, bus.fcw_ready, i >= 2); end
            $display("test_sweep_down: cycle %0d delta=%h done=%b", i, delta, bus.sweep_done);
        end
    endtask

    task automatic test_priority();
        logic [31:0] prev;
        bus.stop = 1'b1; bus.sweep_start = 1'b1;
        bus.sweep_step = 32'h1; bus.sweep_limit = 32'hFFFF_FFFF;
        tick();
        bus.stop = 1'b0; bus.sweep_start = 1'b0;
        total++; if (bus.fcw_ready !== 1'b1) begin bad++; $display("FAIL prio_stop_ready got %b want 1", bus.fcw_ready); end
        tick();
        total++; if (bus.phase_valid !== 1'b0) begin bad++; $display("FAIL prio_stop_valid got %b want 0", bus.phase_valid); end
        prev = bus.phase_out;
        tick();
        total++; if (bus.phase_out !== prev) begin bad++; $display("FAIL prio_acc_held got %h want %h", bus.phase_out, prev); end
        bus.clear = 1'b1; bus.start = 1'b1;
        tick();
        bus.clear = 1'b0; bus.start = 1'b0;
        tick();
        total++; if (bus.phase_out !== 32'h8000_0000) begin bad++; $display("FAIL prio_clear got %h want 80000000", bus.phase_out); end
        total++; if (bus.phase_valid !== 1'b1) begin bad++; $display("FAIL prio_run_valid got %b want 1", bus.phase_valid); end
        tick();
        total++; if (bus.phase_out !== 32'h8000_0050) begin bad++; $display("FAIL prio_run_step got %h want 80000050", bus.phase_out); end
        bus.sweep_step = 32'h1; bus.sweep_limit = 32'hFFFF_FFFF; bus.sweep_start = 1'b1;
        tick();
        bus.sweep_start = 1'b0;
        bus.fcw_in = 32'hDEAD_0000; bus.fcw_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            total++; if (bus.fcw_ready !== 1'b0) begin bad++; $display("FAIL prio_stall_ready[%0d] got %b want 0", i, bus.fcw_ready); end
            total++; if (bus.phase_out !== m_phase) begin bad++; $display("FAIL prio_stall_phase[%0d] got %h want %h", i, bus.phase_out, m_phase); end
        end
        bus.fcw_valid = 1'b0;
        $display("test_priority: phase=%h", bus.phase_out);
    endtask

    task automatic test_async_reset();
        // Still sweeping from test_priority; hit rst between edges.
        #2;
        rst = 1'b1;
        #1;
        total++; if (bus.phase_out !== 32'h0) begin bad++; $display("FAIL arst_phase got %h want 0", bus.phase_out); end
        total++; if (bus.phase_valid !== 1'b0) begin bad++; $display("FAIL arst_valid got %b want 0", bus.phase_valid); end
        total++; if (bus.wrap !== 1'b0) begin bad++; $display("FAIL arst_wrap got %b want 0", bus.wrap); end
        total++; if (bus.sweep_done !== 1'b0) begin bad++; $display("FAIL arst_done got %b want 0", bus.sweep_done); end
        total++; if (bus.fcw_ready !== 1'b1) begin bad++; $display("FAIL arst_ready got %b want 1", bus.fcw_ready); end
        model_reset();
        idle_inputs();
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick();
        total++; if (bus.phase_out !== m_phase || bus.phase_valid !== m_valid) begin
            bad++; $display("FAIL arst_after got %h/%b want %h/%b", bus.phase_out, bus.phase_valid, m_phase, m_valid);
        end
        $display("test_async_reset: outputs cleared");
    endtask

    task automatic test_random();
        logic [31:0] mag;
        for (int n = 0; n < 600; n++) begin
            bus.stop        = ($urandom_range(0, 99) < 4);
            bus.start       = ($urandom_range(0, 99) < 15);
            bus.clear       = ($urandom_range(0, 99) < 3);
            bus.sweep_start = ($urandom_range(0, 99) < 10);
            mag             = $urandom & 32'h0FFF_FFFF;
            if ($urandom_range(0, 3) == 0)      bus.sweep_step = '0;
            else if ($urandom_range(0, 1) == 1) bus.sweep_step = mag;
            else                                bus.sweep_step = -mag;
            bus.sweep_limit = $urandom;
            bus.fcw_valid   = ($urandom_range(0, 99) < 30);
            bus.fcw_in      = $urandom;
            bus.off_load    = ($urandom_range(0, 99) < 5);
            bus.off_in      = $urandom;
            tick();
            total++;
            if (bus.phase_out !== m_phase || bus.phase_valid !== m_valid || bus.wrap !== m_wrap
                || bus.sweep_done !== m_done || bus.fcw_ready !== (m_st != S_SWEEP)) begin
                bad++;
                $display("FAIL random[%0d] got ph=%h v=%b w=%b d=%b r=%b want ph=%h v=%b w=%b d=%b r=%b",
                         n, bus.phase_out, bus.phase_valid, bus.wrap, bus.sweep_done, bus.fcw_ready,
                         m_phase, m_valid, m_wrap, m_done, m_st != S_SWEEP);
            end
        end
        idle_inputs();
        $display("test_random: 600 cycles");
    endtask

    initial begin
        test_reset();
        test_wrap();
        test_offset();
        test_sweep_up();
        test_sweep_down();
        test_priority();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/nco_phase_accumulator.md
# nco_phase_accumulator

- Phase-generation stage of the NCO.
- Integrates a frequency control word (FCW) every clock and adds a programmable phase offset.
- Optionally performs a linear FCW sweep (chirp) toward a limit.
- Drives a registered 32-bit phase word directly into the 32-to-16 quantizer stage that follows it.

## Interface
- PHASE_W, 32: width of accumulator, FCW, offset, limit and phase output.
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-high reset.
- fcw_in  in  PHASE_W  new frequency control word (unsigned).
- fcw_valid  in  1  fcw_in is valid.
- fcw_ready  out  1  block accepts fcw_in this cycle.
- off_in  in  PHASE_W  phase offset value.
- off_load  in  1  load off_in into the offset register.
- start  in  1  pulse: IDLE -> RUN.
- stop  in  1  pulse: any state -> IDLE.
- clear  in  1  pulse: accumulator <= 0.
- sweep_start  in  1  pulse: RUN -> SWEEP.
- sweep_step  in  PHASE_W  signed per-cycle FCW increment, sampled on sweep_start.
- sweep_limit  in  PHASE_W  unsigned final FCW, sampled on sweep_start.
- phase_out  out  PHASE_W  registered accumulator + offset, modulo 2^PHASE_W.
- phase_valid  out  1  phase_out is a running-phase sample.
- wrap  out  1  one-cycle pulse aligned with the first phase_out sample after an accumulator carry-out.
- sweep_done  out  1  one-cycle pulse when the sweep reaches its limit.

## Operation
- Registers:
  - acc: accumulator.
  - fcw_act: active FCW.
  - off: offset.
  - step_r, lim_r: latched sweep parameters.
  - state: FSM state.
- Reset values:
  - acc=0, fcw_act=0, off=0, step_r=0, lim_r=0, state=IDLE.
  - Outputs: phase_out=0, phase_valid=0, wrap=0, sweep_done=0, fcw_ready=1.
- FSM states:
  - IDLE: acc holds; phase_valid=0.
  - RUN: acc <= acc + fcw_act.
  - SWEEP: acc <= acc + fcw_act, and fcw_act steps toward lim_r.
- Transitions, priority stop > sweep_start > start:
  - stop from any state -> IDLE.
  - start in IDLE -> RUN.
  - sweep_start in RUN with sweep_step != 0 -> SWEEP.
  - sweep_start with sweep_step == 0, or outside RUN, is ignored.
  - SWEEP -> RUN on limit reached.
- clear:
  - Forces acc <= 0 in any state; overrides the increment that cycle.
  - Does not change state, fcw_act or off.
- FCW handshake:
  - fcw_ready = 1 in IDLE and RUN, 0 in SWEEP.
  - Transfer when fcw_valid && fcw_ready: fcw_act <= fcw_in at that edge.
  - The acc increment in the same edge uses the old fcw_act.
- Sweep update, 33-bit arithmetic, checked each SWEEP cycle:
  - Positive step: if fcw_act + step_r >= lim_r (unsigned, carry counts as exceeded), then fcw_act <= lim_r, pulse sweep_done, go to RUN. Otherwise fcw_act <= fcw_act + step_r.
  - Negative step: if fcw_act + step_r <= lim_r, or borrow occurs, then clamp to lim_r, pulse sweep_done, go to RUN. Otherwise add.
- stop during SWEEP: fcw_act keeps its current intermediate value; no sweep_done.
- Accumulator wraps modulo 2^PHASE_W; the carry-out is latched into the wrap pipeline.
- off_load: off <= off_in; takes effect on phase_out one cycle later.

## Timing
- Latency:
  - phase_out(n+1) = acc(n) + off(n), registered.
  - phase_valid(n+1) = (state(n) != IDLE).
  - wrap(n+1) = carry of the acc update that produced acc(n).
- start at edge k:
  - First incremented acc appears at edge k+1.
  - phase_out equals fcw_act at edge k+2.
- sweep_done is asserted in the cycle following the edge where the clamp is written.
- Asynchronous rst mid-sweep or mid-handshake:
  - All registers return to reset values immediately.
  - Any pending FCW transfer is lost.
- Simultaneous events in one cycle:
  - fcw transfer + sweep_start: the transfer completes first, and SWEEP begins from the new fcw_act on the next cycle.
  - clear + start: acc = 0 and state = RUN.

## Structure
- Shared package nco_pkg:
  - PHASE_W default.
  - Enum for the IDLE/RUN/SWEEP states.
  - Sweep compare helper function.
- One natural sub-module, nco_fcw_sweep:
  - Owns fcw_act, step_r, lim_r, the handshake and the clamp logic.
  - Outputs fcw_act and sweep_done.
- The accumulator, FSM and output registers stay in the top.

## Test plan
- Reset then fcw_in=0x4000_0000 accepted, start:
  - phase_out sequence 0x4000_0000, 0x8000_0000, 0xC000_0000, 0x0000_0000.
  - wrap=1 only with the 0x0000_0000 sample.
- Running with fcw=0x1000_0000, off_load 0x8000_0000: phase_out jumps by +0x8000_0000 exactly one cycle after the load; acc is unaffected.
- Sweep up:
  - Setup: fcw=0x100, step=0x100, limit=0x480.
  - fcw_act sequence 0x200, 0x300, 0x400, 0x480 (clamped).
  - Single sweep_done; then fcw_ready=1.
- Sweep down:
  - Setup: fcw=0x300, step=-0x200 (0xFFFF_FE00), limit=0x50.
  - fcw_act 0x100 then 0x50 (clamped, borrow-safe); then sweep_done.
- Priority:
  - stop + sweep_start in the same cycle gives IDLE with acc held.
  - clear + start gives acc=0 and RUN; fcw_valid in SWEEP stalls with fcw_ready=0.
- Async rst asserted mid-sweep between clock edges: all outputs 0 and fcw_ready=1 immediately, before the next edge.
